uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// UART-driven memory loader: receives 'W'/'R' commands over an 8N1 serial
// link, performs one 32-bit bus access per command and answers with ACK,
// NAK or the four read-data bytes.
module uart_loader #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam int             GW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0]  GAP_MAX   = GW'(TIMEOUT_CYCLES);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_MEM, P_RESP} pstate_t;

  // Receiver signals
  logic          rx_meta, rx_sync, rx_prev;
  logic          rx_busy, rx_valid, rx_ferr, rx_sample;
  logic [3:0]    rx_bit;
  logic [CW-1:0] rx_cnt;
  logic [7:0]    rx_shift;

  // Transmitter signals
  logic          tx_busy, tx_start;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;
  logic [7:0]    tx_shift, tx_data;

  // Parser signals
  pstate_t       state, state_nxt;
  logic          is_write, nak_pend, timeout, is_cmd;
  logic          mode_we, addr_we, data_we, nak_set, resp_start, resp_last;
  logic [1:0]    byte_idx, resp_idx;
  logic [31:0]   rdata_q;
  logic [GW-1:0] gap_cnt;

  assign mem_instr = 1'b0;
  assign timeout   = (gap_cnt == GAP_MAX);
  assign is_cmd    = (rx_shift == CMD_W) || (rx_shift == CMD_R);
  assign rx_sample = rx_busy && (rx_cnt == ((rx_bit == 4'd0) ? HALF_LAST : BIT_LAST));

  // Two-flop synchronizer plus previous-sample flop for edge detection.
  // rx_prev resets low, so a start edge is only possible once the line
  // has been seen high after reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchronizer chain.
    if (rst) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver: start check at half bit, then data and stop at full-bit spacing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_busy  <= 1'b0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_bit   <= '0;
      rx_cnt   <= '0;
      rx_shift <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_busy) begin
        rx_cnt <= '0;
        rx_bit <= '0;
        if (rx_prev && !rx_sync) rx_busy <= 1'b1;
      end else if (rx_sample) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd0) begin
          if (rx_sync) rx_busy <= 1'b0;   // glitch: line back high mid-start
          else         rx_bit  <= 4'd1;
        end else if (rx_bit == 4'd9) begin
          rx_busy  <= 1'b0;
          rx_valid <= rx_sync;
          rx_ferr  <= !rx_sync;
        end else begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
          rx_bit   <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  // Transmitter: start bit, 8 data bits LSB first, stop bit, each BIT_LAST+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_bit   <= '0;
      tx_cnt   <= '0;
      tx_shift <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy  <= 1'b1;
        uart_tx  <= 1'b0;
        tx_shift <= tx_data;
        tx_bit   <= '0;
        tx_cnt   <= '0;
      end
    end else if (tx_cnt == BIT_LAST) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        tx_bit <= tx_bit + 4'd1;
        if (tx_bit == 4'd8) begin
          uart_tx <= 1'b1;
        end else begin
          uart_tx  <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[7:1]};
        end
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  // Parser state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= P_IDLE;
    else     state <= state_nxt;
  end

  // Parser next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      P_IDLE: if (rx_valid && is_cmd) state_nxt = P_ADDR;
      P_ADDR: begin
        if (rx_ferr || timeout)                 state_nxt = P_IDLE;
        else if (rx_valid && byte_idx == 2'd3)  state_nxt = is_write ? P_DATA : P_MEM;
      end
      P_DATA: begin
        if (rx_ferr || timeout)                 state_nxt = P_IDLE;
        else if (rx_valid && byte_idx == 2'd3)  state_nxt = P_MEM;
      end
      P_MEM:  if (mem_valid && mem_ready)       state_nxt = P_RESP;
      P_RESP: if (resp_start && resp_last)      state_nxt = P_IDLE;
      default:                                  state_nxt = P_IDLE;
    endcase
  end

  // Parser output decode: datapath strobes and transmit requests.
  always_comb begin
    mode_we    = (state == P_IDLE) && rx_valid && is_cmd;
    nak_set    = (state == P_IDLE) && rx_valid && !is_cmd;
    addr_we    = (state == P_ADDR) && rx_valid;
    data_we    = (state == P_DATA) && rx_valid;
    resp_start = (state == P_RESP) && !tx_busy;
    resp_last  = is_write || (resp_idx == 2'd3);
    tx_start   = resp_start || (nak_pend && !tx_busy && state != P_RESP);
    tx_data    = NAK;
    if (state == P_RESP) tx_data = is_write ? ACK : rdata_q[{resp_idx, 3'b000} +: 8];
  end

  // Parser datapath: command assembly, bus handshake, gap timer, NAK pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_write  <= 1'b0;
      nak_pend  <= 1'b0;
      byte_idx  <= '0;
      resp_idx  <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rdata_q   <= '0;
      gap_cnt   <= '0;
    end else begin
      if (mode_we) begin
        is_write  <= (rx_shift == CMD_W);
        mem_wstrb <= (rx_shift == CMD_W) ? 4'hF : 4'h0;
        byte_idx  <= '0;
        resp_idx  <= '0;
      end
      if (addr_we) begin
        mem_addr <= {rx_shift, mem_addr[31:8]};
        byte_idx <= byte_idx + 2'd1;
      end
      if (data_we) begin
        mem_wdata <= {rx_shift, mem_wdata[31:8]};
        byte_idx  <= byte_idx + 2'd1;
      end
      if (resp_start) resp_idx <= resp_idx + 2'd1;

      if (nak_set)                       nak_pend <= 1'b1;
      else if (tx_start && !resp_start)  nak_pend <= 1'b0;

      // Request rises the cycle after P_MEM entry; drops after the ready cycle.
      if (mem_valid && mem_ready) begin
        mem_valid <= 1'b0;
        rdata_q   <= mem_rdata;
      end else if (state == P_MEM) begin
        mem_valid <= 1'b1;
      end

      if (rx_valid || !(state == P_ADDR || state == P_DATA)) gap_cnt <= '0;
      else if (!timeout)                                     gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed and random commands, a
// behavioural bus responder, a serial response monitor and a command-level
// reference model.
module tb_uart_loader;

  localparam int CPB = 4;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b0;
  logic        uart_tx, mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;

  uart_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- bus responder ----------------
  int          ready_delay = 0;
  logic [31:0] rdata_val   = 32'h0;
  bit          glitch_ready = 1'b0;
  int          vcnt = 0;
  int          unstable = 0;
  logic [31:0] got_addr[$], got_wdata[$];
  logic [3:0]  got_wstrb[$];
  logic        got_instr[$];
  int          got_vlen[$];

  always @(negedge clk) begin
    if (rst) begin
      mem_ready = 1'b0;
      vcnt = 0;
    end else if (mem_valid) begin
      if (vcnt == 0) begin
        got_addr.push_back(mem_addr);
        got_wdata.push_back(mem_wdata);
        got_wstrb.push_back(mem_wstrb);
        got_instr.push_back(mem_instr);
      end else if (mem_addr !== got_addr[got_addr.size()-1] ||
                   mem_wdata !== got_wdata[got_wdata.size()-1] ||
                   mem_wstrb !== got_wstrb[got_wstrb.size()-1]) begin
        unstable++;
      end
      if (vcnt == ready_delay) begin
        mem_ready = 1'b1;
        mem_rdata = rdata_val;
      end else begin
        mem_ready = 1'b0;
      end
      vcnt++;
    end else begin
      if (vcnt != 0) got_vlen.push_back(vcnt);
      vcnt = 0;
      mem_ready = glitch_ready;
      if (glitch_ready) mem_rdata = ~rdata_val;
    end
  end

  // ---------------- serial response monitor ----------------
  logic [7:0] tx_q[$];
  int         tx_bad = 0;
  logic [9:0] mon_bits;
  bit         mon_ok;

  always begin
    @(negedge clk);
    if (!rst && uart_tx === 1'b0) begin
      mon_ok = 1'b1;
      for (int b = 0; b < 10; b++) begin
        for (int k = 0; k < CPB; k++) begin
          if (!(b == 0 && k == 0)) @(negedge clk);
          if (k == 0) mon_bits[b] = uart_tx;
          else if (uart_tx !== mon_bits[b]) mon_ok = 1'b0;
        end
      end
      if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) mon_ok = 1'b0;
      if (mon_ok) tx_q.push_back(mon_bits[8:1]);
      else        tx_bad++;
    end
  end

  // ---------------- stimulus and reference model ----------------
  logic [7:0]  cmd_q[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_addr[$], exp_wdata[$];
  logic [3:0]  exp_wstrb[$];
  bit          exp_write[$];
  int          exp_vlen[$];

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_cmd();
    foreach (cmd_q[i]) send_byte(cmd_q[i]);
  endtask

  // Expected bus access and serial reply for the command held in cmd_q.
  task automatic model_cmd();
    logic [31:0] a, d;
    if (cmd_q.size() == 9 && cmd_q[0] == 8'h57) begin
      a = {cmd_q[4], cmd_q[3], cmd_q[2], cmd_q[1]};
      d = {cmd_q[8], cmd_q[7], cmd_q[6], cmd_q[5]};
      exp_addr.push_back(a); exp_wdata.push_back(d); exp_wstrb.push_back(4'hF);
      exp_write.push_back(1'b1); exp_vlen.push_back(ready_delay + 1);
      exp_tx.push_back(8'h06);
    end else if (cmd_q.size() == 5 && cmd_q[0] == 8'h52) begin
      a = {cmd_q[4], cmd_q[3], cmd_q[2], cmd_q[1]};
      exp_addr.push_back(a); exp_wdata.push_back(32'h0); exp_wstrb.push_back(4'h0);
      exp_write.push_back(1'b0); exp_vlen.push_back(ready_delay + 1);
      for (int i = 0; i < 4; i++) exp_tx.push_back(rdata_val[8*i +: 8]);
    end else begin
      foreach (cmd_q[i]) exp_tx.push_back(8'h15);
    end
  endtask

  task automatic check_results(input string tag);
    int waited;
    waited = 0;
    while (tx_q.size() < exp_tx.size() && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    repeat (60) @(negedge clk);
    check({tag, ".tx_count"}, tx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      check($sformatf("%s.tx_byte%0d", tag, i), {24'h0, tx_q[i]}, {24'h0, exp_tx[i]});
    check({tag, ".tx_frame_errs"}, tx_bad, 0);
    check({tag, ".bus_count"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check($sformatf("%s.addr%0d", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s.wstrb%0d", tag, i), {28'h0, got_wstrb[i]}, {28'h0, exp_wstrb[i]});
      check($sformatf("%s.instr%0d", tag, i), {31'h0, got_instr[i]}, 32'h0);
      if (exp_write[i]) check($sformatf("%s.wdata%0d", tag, i), got_wdata[i], exp_wdata[i]);
      if (i < got_vlen.size()) check($sformatf("%s.vlen%0d", tag, i), got_vlen[i], exp_vlen[i]);
      else                     check($sformatf("%s.vlen%0d", tag, i), 32'hFFFF_FFFF, exp_vlen[i]);
    end
    check({tag, ".bus_unstable"}, unstable, 0);
    tx_q.delete(); exp_tx.delete();
    got_addr.delete(); got_wdata.delete(); got_wstrb.delete(); got_instr.delete(); got_vlen.delete();
    exp_addr.delete(); exp_wdata.delete(); exp_wstrb.delete(); exp_write.delete(); exp_vlen.delete();
  endtask

  logic [31:0] r_a, r_d;
  logic [7:0]  r_bad;
  int          r_kind, waited_v;

  initial begin
    // Reset values, with the serial line held low through reset.
    repeat (5) @(negedge clk);
    check("rst.uart_tx", {31'h0, uart_tx}, 32'h1);
    check("rst.mem_valid", {31'h0, mem_valid}, 32'h0);
    check("rst.mem_instr", {31'h0, mem_instr}, 32'h0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.mem_wdata", mem_wdata, 32'h0);
    check("rst.mem_wstrb", {28'h0, mem_wstrb}, 32'h0);

    // Line still low after reset release must not look like a start bit.
    rst = 1'b0;
    repeat (20) @(negedge clk);
    uart_rx = 1'b1;
    repeat (100) @(negedge clk);
    check_results("no_false_start");

    // Directed write, ready three cycles after valid.
    ready_delay = 3;
    cmd_q = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model_cmd(); send_cmd(); check_results("write_dir");

    // Directed read, ready in the first valid cycle.
    ready_delay = 0;
    rdata_val = 32'h12345678;
    cmd_q = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h00};
    model_cmd(); send_cmd(); check_results("read_dir");

    // Unknown command byte.
    cmd_q = '{8'h41};
    model_cmd(); send_cmd(); check_results("nak_dir");

    // One-cycle low glitch on the line must not produce a byte.
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (60) @(negedge clk);
    check_results("rx_glitch");

    // Stray mem_ready pulses while no request is outstanding.
    glitch_ready = 1'b1;
    ready_delay = 2;
    rdata_val = $urandom;
    cmd_q = '{8'h52, 8'h21, 8'h43, 8'h65, 8'h87};
    model_cmd(); send_cmd(); check_results("stray_ready");
    glitch_ready = 1'b0;

    // Gap timeout drops a partial command silently.
    ready_delay = 1;
    cmd_q = '{8'h57, 8'h00, 8'h00};
    send_cmd();
    repeat (250) @(negedge clk);
    rdata_val = $urandom;
    cmd_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
    model_cmd(); send_cmd(); check_results("timeout");

    // Framing error inside the address phase restarts the parser.
    send_byte(8'h52);
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    repeat (3 * CPB) @(negedge clk);
    r_a = $urandom;
    rdata_val = $urandom;
    cmd_q = '{8'h52, r_a[7:0], r_a[15:8], r_a[23:16], r_a[31:24]};
    model_cmd(); send_cmd(); check_results("framing");

    // Random commands against the model.
    for (int i = 0; i < 6; i++) begin
      r_kind = $urandom_range(0, 2);
      r_a = $urandom;
      r_d = $urandom;
      ready_delay = $urandom_range(0, 5);
      rdata_val = $urandom;
      if (r_kind == 0) begin
        cmd_q = '{8'h57, r_a[7:0], r_a[15:8], r_a[23:16], r_a[31:24],
                  r_d[7:0], r_d[15:8], r_d[23:16], r_d[31:24]};
      end else if (r_kind == 1) begin
        cmd_q = '{8'h52, r_a[7:0], r_a[15:8], r_a[23:16], r_a[31:24]};
      end else begin
        do r_bad = 8'($urandom_range(0, 255)); while (r_bad == 8'h57 || r_bad == 8'h52);
        cmd_q = '{r_bad};
      end
      model_cmd(); send_cmd(); check_results($sformatf("rand%0d", i));
    end

    // Reset while a bus request is outstanding.
    ready_delay = 100000;
    r_d = $urandom;
    cmd_q = '{8'h57, 8'h08, 8'h00, 8'h00, 8'h40, r_d[7:0], r_d[15:8], r_d[23:16], r_d[31:24]};
    send_cmd();
    waited_v = 0;
    while (!mem_valid && waited_v < 200) begin
      @(negedge clk);
      waited_v++;
    end
    check("rstmid.valid_seen", {31'h0, mem_valid}, 32'h1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rstmid.mem_valid", {31'h0, mem_valid}, 32'h0);
    check("rstmid.uart_tx", {31'h0, uart_tx}, 32'h1);
    check("rstmid.mem_addr", mem_addr, 32'h0);
    check("rstmid.mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    got_addr.delete(); got_wdata.delete(); got_wstrb.delete(); got_instr.delete(); got_vlen.delete();
    repeat (100) @(negedge clk);
    check_results("rstmid_silent");
    ready_delay = 0;
    rdata_val = $urandom;
    cmd_q = '{8'h52, 8'hFF, 8'hEE, 8'hDD, 8'hCC};
    model_cmd(); send_cmd(); check_results("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
